// File: rtl/keypad_scan.sv
// keypad_scan: 4x3 matrix keypad scanner with synchronized rows, debounced one-hot key and binary code.
// Ports: clock/reset (async, active-high); row_in[3:0] active-low rows; col_out[2:0] active-low column drive;
// Key[11:0] one-hot debounced key (bit = 3*row+col); key_valid one-cycle press pulse; key_code binary key (15 = none).
module keypad_scan #(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  row_in,
  output logic [2:0]  col_out,
  output logic [11:0] Key,
  output logic        key_valid,
  output logic [3:0]  key_code
);
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;
  state_t state, state_n;
  logic [3:0] r1, r2, low, idx, code_n;
  logic [1:0] col, col_n, col_nx, row, row_n, low_idx;
  logic [15:0] div, div_n, cnt, cnt_n;
  logic [11:0] key_n;
  logic valid_n, one_low, match, dwell_end, deb_last;
  assign low       = ~r2;
  assign one_low   = (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
  assign low_idx   = low[0] ? 2'd0 : low[1] ? 2'd1 : low[2] ? 2'd2 : 2'd3;
  assign col_nx    = (col == 2'd2) ? 2'd0 : col + 2'd1;
  assign idx       = {1'b0, row, 1'b0} + {2'b00, row} + {2'b00, col};
  // the captured row must be the only low row; any other pattern is a bounce
  assign match     = r2 == ~(4'b0001 << row);
  assign dwell_end = div == 16'(SCAN_DIV - 1);
  assign deb_last  = cnt == 16'(DEBOUNCE_CNT - 1);
  assign col_out   = (col == 2'd0) ? 3'b110 : (col == 2'd1) ? 3'b101 : 3'b011;
  always_comb begin
    state_n = state;
    col_n   = col;
    div_n   = div;
    cnt_n   = cnt;
    row_n   = row;
    key_n   = Key;
    valid_n = 1'b0;
    code_n  = key_code;
    unique case (state)
      SCAN: begin
        div_n = dwell_end ? 16'd0 : div + 16'd1;
        if (dwell_end && one_low) begin
          state_n = DEBOUNCE;
          row_n   = low_idx;
          cnt_n   = 16'd0;
        end else if (dwell_end) col_n = col_nx;
      end
      DEBOUNCE: begin
        cnt_n = cnt + 16'd1;
        if (!match) begin
          state_n = SCAN;
          col_n   = col_nx;
          div_n   = 16'd0;
        end else if (deb_last) begin
          state_n = HELD;
          key_n   = 12'b1 << idx;
          valid_n = 1'b1;
          code_n  = (idx < 4'd9) ? idx + 4'd1 : (idx == 4'd9) ? 4'd10 : (idx == 4'd10) ? 4'd0 : 4'd11;
        end
      end
      HELD: begin
        if (r2[row]) begin
          state_n = RELEASE;
          cnt_n   = 16'd0;
        end
      end
      RELEASE: begin
        cnt_n = (r2 != 4'hF) ? 16'd0 : cnt + 16'd1;
        if (r2 == 4'hF && deb_last) begin
          state_n = SCAN;
          key_n   = 12'd0;
          code_n  = 4'd15;
          col_n   = col_nx;
          div_n   = 16'd0;
        end
      end
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      r1        <= 4'hF;
      r2        <= 4'hF;
      col       <= 2'd0;
      div       <= 16'd0;
      cnt       <= 16'd0;
      row       <= 2'd0;
      Key       <= 12'd0;
      key_valid <= 1'b0;
      key_code  <= 4'd15;
    end else begin
      state     <= state_n;
      r1        <= row_in;
      r2        <= r1;
      col       <= col_n;
      div       <= div_n;
      cnt       <= cnt_n;
      row       <= row_n;
      Key       <= key_n;
      key_valid <= valid_n;
      key_code  <= code_n;
    end
  end
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed self-checking bench for keypad_scan with a simple keypad model.
module tb_keypad_scan;
  logic clk = 1'b0, rst = 1'b0;
  logic [3:0] row_in, model, ovr = 4'hF;
  logic [2:0] col_out;
  logic [11:0] key;
  logic key_valid;
  logic [3:0] key_code;
  logic pressed = 1'b0;
  logic [1:0] prow = 2'd0, pcol = 2'd0, mode = 2'd0;
  int checks = 0, failures = 0;
  keypad_scan dut (
    .clock(clk), .reset(rst), .row_in(row_in), .col_out(col_out),
    .Key(key), .key_valid(key_valid), .key_code(key_code)
  );
  always #5 clk = ~clk;
  assign model  = (pressed && !col_out[pcol]) ? ~(4'b0001 << prow) : 4'hF;
  assign row_in = (mode == 2'd0) ? model : (mode == 2'd1) ? ovr : (col_out == 3'b101 ? 4'b1100 : 4'hF);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic wait_key(input string tag);
    int n = 0;
    while (key == 12'd0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(key != 12'd0), 32'd1);
  endtask
  initial begin
    int vc, kc, cc;
    logic [2:0] pc;
    #2 rst = 1'b1;
    #1;
    check("rst_col", 32'(col_out), 32'b110);
    check("rst_key", 32'(key), 32'd0);
    check("rst_code", 32'(key_code), 32'd15);
    check("rst_valid", 32'(key_valid), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(posedge clk);
    #1 check("scan_c0_hold", 32'(col_out), 32'b110);
    @(posedge clk);
    #1 check("scan_c1", 32'(col_out), 32'b101);
    repeat (16) @(posedge clk);
    #1 check("scan_c2", 32'(col_out), 32'b011);
    repeat (16) @(posedge clk);
    #1 check("scan_wrap", 32'(col_out), 32'b110);
    prow = 2'd0; pcol = 2'd1; pressed = 1'b1;
    wait_key("press2_seen");
    check("press2_key", 32'(key), 32'h002);
    check("press2_code", 32'(key_code), 32'd2);
    check("press2_valid", 32'(key_valid), 32'd1);
    vc = 0;
    repeat (20) begin
      @(negedge clk);
      vc += int'(key_valid);
    end
    check("press2_one_pulse", 32'(vc), 32'd0);
    check("press2_held_key", 32'(key), 32'h002);
    check("press2_frozen_col", 32'(col_out), 32'b101);
    pressed = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("rel2_still_key", 32'(key), 32'h002);
    @(posedge clk);
    #1 check("rel2_key_gone", 32'(key), 32'd0);
    check("rel2_code", 32'(key_code), 32'd15);
    check("rel2_next_col", 32'(col_out), 32'b011);
    repeat (15) @(posedge clk);
    #1 check("rel2_fresh_dwell", 32'(col_out), 32'b011);
    @(posedge clk);
    #1 check("rel2_dwell_end", 32'(col_out), 32'b110);
    mode = 2'd1; ovr = 4'hF; vc = 0; kc = 0;
    for (int e = 1; e <= 50; e++) begin
      @(posedge clk);
      #1;
      vc += int'(key_valid);
      kc += int'(key != 12'd0);
      if (e == 28) check("bounce_col_adv", 32'(col_out), 32'b101);
      if (e == 44) check("bounce_scan_cont", 32'(col_out), 32'b011);
      ovr = ((e >= 13 && e <= 16) || (e >= 18 && e <= 20)) ? 4'b1110 : 4'hF;
    end
    check("bounce_no_valid", 32'(vc), 32'd0);
    check("bounce_no_key", 32'(kc), 32'd0);
    mode = 2'd2; vc = 0; kc = 0; cc = 0; pc = col_out;
    repeat (100) begin
      @(negedge clk);
      vc += int'(key_valid);
      kc += int'(key != 12'd0);
      cc += int'(col_out != pc);
      pc = col_out;
    end
    check("multi_no_valid", 32'(vc), 32'd0);
    check("multi_no_key", 32'(kc), 32'd0);
    check("multi_scanning", 32'(cc >= 5), 32'd1);
    mode = 2'd0; prow = 2'd3; pcol = 2'd2; pressed = 1'b1;
    wait_key("hash_seen");
    check("hash_key", 32'(key), 32'h800);
    check("hash_code", 32'(key_code), 32'd11);
    check("hash_valid", 32'(key_valid), 32'd1);
    repeat (3) @(negedge clk);
    check("hash_held", 32'(key), 32'h800);
    rst = 1'b1;
    #1;
    check("mid_rst_key", 32'(key), 32'd0);
    check("mid_rst_code", 32'(key_code), 32'd15);
    check("mid_rst_col", 32'(col_out), 32'b110);
    vc = 0;
    repeat (5) begin
      @(negedge clk);
      vc += int'(key_valid);
    end
    check("mid_rst_no_valid", 32'(vc), 32'd0);
    pressed = 1'b0;
    rst = 1'b0;
    repeat (15) @(posedge clk);
    #1 check("post_rst_c0", 32'(col_out), 32'b110);
    @(posedge clk);
    #1 check("post_rst_c1", 32'(col_out), 32'b101);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
